// File: rtl/ifetch_queue_pkg.sv
// rtl/ifetch_queue_pkg.sv - shared constants, state enum and pc helper for the fetch queue
package ifetch_queue_pkg;

  localparam int XLEN       = 32;
  localparam int INSN_BYTES = 4;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0080_0000;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } ifq_state_e;

  // Instructions are word aligned; low address bits carry no meaning.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~(XLEN'(INSN_BYTES - 1));
  endfunction

endpackage

// File: rtl/ifetch_queue_if.sv
// rtl/ifetch_queue_if.sv - memory request/response, redirect and instruction channels of the fetch queue
interface ifetch_queue_if;
  import ifetch_queue_pkg::*;

  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_rsp_valid;
  logic [XLEN-1:0] mem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst_data;
  logic [XLEN-1:0] inst_pc;

  // Fetch queue side.
  modport master (
    output mem_req_valid, mem_req_addr, inst_valid, inst_data, inst_pc,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, redirect_valid, redirect_pc, inst_ready
  );

  // Memory / core side.
  modport slave (
    input  mem_req_valid, mem_req_addr, inst_valid, inst_data, inst_pc,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, redirect_valid, redirect_pc, inst_ready
  );

endinterface

// File: rtl/ifetch_queue_fifo.sv
// rtl/ifetch_queue_fifo.sv - synchronous prefetch FIFO holding {pc, insn} entries
module ifq_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage; contents are don't-care while the slot is empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - sequential instruction fetch with prefetch FIFO and redirect draining; IFQ_BYPASS_EN enables empty-FIFO response bypass
module ifetch_queue import ifetch_queue_pkg::*; #(
  parameter int              DEPTH    = 4,
  parameter int              MAX_OUT  = 2,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  ifetch_queue_if.master bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam logic [PW-1:0] PLAST = PW'(MAX_OUT - 1);

  ifq_state_e      state;
  ifq_state_e      state_nx;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   drop_calc;
  logic [XLEN-1:0] fetch_pc;

  logic [XLEN-1:0] pcq [MAX_OUT];
  logic [PW-1:0]   pcq_wr;
  logic [PW-1:0]   pcq_rd;
  logic [XLEN-1:0] rsp_pc;

  logic            f_push;
  logic            f_pop;
  logic            f_flush;
  logic            f_full;
  logic            f_empty;
  logic [CW-1:0]   f_count;
  logic [2*XLEN-1:0] f_rdata;

  logic            req_acc;
  logic            rsp;
  logic            redir;
  logic            credit_ok;
  logic            bypass_hit;
  logic            req_valid;
  logic            out_valid;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_data;

  assign redir   = bus.redirect_valid;
  assign rsp     = bus.mem_rsp_valid;
  assign req_acc = req_valid && bus.mem_req_ready;
  assign rsp_pc  = pcq[pcq_rd];

  // Credits come only from registered counts, so a response never frees a slot in its own cycle.
  assign credit_ok = (outstanding < CW'(MAX_OUT)) &&
                     (({1'b0, f_count} + {1'b0, outstanding}) < (CW + 1)'(DEPTH));

  // Everything still in flight after this cycle is stale once a redirect lands.
  assign drop_calc = outstanding + CW'(req_acc) - CW'(rsp);

  ifq_fifo #(
    .WIDTH (2 * XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (f_push),
    .pop     (f_pop),
    .flush   (f_flush),
    .wdata   ({rsp_pc, bus.mem_rsp_data}),
    .rdata   (f_rdata),
    .full    (f_full),
    .empty   (f_empty),
    .count   (f_count)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= FETCH;
    else          state <= state_nx;
  end

  // Next state: redirect dominates; DRAIN ends with the last stale response.
  always_comb begin
    state_nx = state;
    if (redir) begin
      state_nx = (drop_calc != '0) ? DRAIN : FETCH;
    end else if (state == DRAIN && rsp && drop_cnt == CW'(1)) begin
      state_nx = FETCH;
    end
  end

  // Outputs and FIFO controls; redirect kills the request and any push/pop in its cycle.
  always_comb begin
    req_valid = reset_n && (state == FETCH) && !redir && credit_ok;
`ifdef IFQ_BYPASS_EN
    bypass_hit = reset_n && (state == FETCH) && f_empty && bus.inst_ready && rsp && !redir;
`else
    bypass_hit = 1'b0;
`endif
    f_push    = (state == FETCH) && rsp && !redir && !bypass_hit;
    f_pop     = bus.inst_ready && !f_empty && !redir;
    f_flush   = redir;
    out_valid = !f_empty || bypass_hit;
    out_pc    = '0;
    out_data  = '0;
    if (bypass_hit) begin
      out_pc   = rsp_pc;
      out_data = bus.mem_rsp_data;
    end else if (!f_empty) begin
      out_pc   = f_rdata[2*XLEN-1:XLEN];
      out_data = f_rdata[XLEN-1:0];
    end
  end

  assign bus.mem_req_valid = req_valid;
  assign bus.mem_req_addr  = fetch_pc;
  assign bus.inst_valid    = out_valid;
  assign bus.inst_pc       = out_pc;
  assign bus.inst_data     = out_data;

  // Fetch pc, outstanding/drop counters and pc tracking pointers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      pcq_wr      <= '0;
      pcq_rd      <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_acc) - CW'(rsp);
      if (req_acc) pcq_wr <= (pcq_wr == PLAST) ? '0 : pcq_wr + 1'b1;
      if (rsp)     pcq_rd <= (pcq_rd == PLAST) ? '0 : pcq_rd + 1'b1;
      if (redir) begin
        fetch_pc <= align_pc(bus.redirect_pc);
        drop_cnt <= drop_calc;
      end else begin
        if (req_acc) fetch_pc <= fetch_pc + XLEN'(INSN_BYTES);
        if (state == DRAIN && rsp) drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  // Pc of each issued request, retired in order by its response.
  always_ff @(posedge clk) begin
    if (req_acc) pcq[pcq_wr] <= fetch_pc;
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - randomized bench for ifetch_queue against an epoch-tagged fetch stream model
module tb_ifetch_queue;
  import ifetch_queue_pkg::*;

  localparam int DEPTH   = 4;
  localparam int MAX_OUT = 2;
  localparam logic [31:0] RST_PC = 32'h0080_0000;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  ifetch_queue_if bus ();

  ifetch_queue #(
    .DEPTH    (DEPTH),
    .MAX_OUT  (MAX_OUT),
    .RESET_PC (RST_PC)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          ready_cyc;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] exp_q[$];
  int          epoch = 0;
  int          cyc   = 0;
  logic [31:0] m_pc  = RST_PC;

  int p_ready  = 100;
  int p_rsp    = 100;
  int p_iready = 100;
  int p_redir  = 0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic set_knobs(input int r, input int rs, input int ir, input int rd);
    p_ready = r; p_rsp = rs; p_iready = ir; p_redir = rd;
  endtask

  task automatic cycle(input bit f_redir = 1'b0, input logic [31:0] f_pc = 32'h0, input bit f_rsp = 1'b0);
    logic        ready, iready, redir, rsp, exp_rv, exp_iv, byp, acc;
    logic [31:0] rpc, exp_pc;
    int          stale, out, occ;
    pend_t       h;
    @(negedge clk);
    ready  = ($urandom_range(99) < p_ready);
    iready = ($urandom_range(99) < p_iready);
    redir  = f_redir || ($urandom_range(99) < p_redir);
    rpc    = f_redir ? f_pc : $urandom;
    rsp    = (pend.size() > 0) && (pend[0].ready_cyc <= cyc) &&
             (f_rsp || ($urandom_range(99) < p_rsp));
    bus.mem_req_ready  = ready;
    bus.inst_ready     = iready;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    bus.mem_rsp_valid  = rsp;
    bus.mem_rsp_data   = rsp ? mem_word(pend[0].addr) : $urandom;
    #1;
    stale = 0;
    foreach (pend[i]) if (pend[i].epoch != epoch) stale++;
    out = pend.size();
    occ = exp_q.size();
    exp_rv = !redir && (stale == 0) && (out < MAX_OUT) && (occ + out < DEPTH);
    check("req_valid", bus.mem_req_valid, exp_rv);
    if (exp_rv) check("req_addr", bus.mem_req_addr, m_pc);
`ifdef IFQ_BYPASS_EN
    byp = rsp && (pend[0].epoch == epoch) && !redir && (occ == 0) && iready;
`else
    byp = 1'b0;
`endif
    exp_iv = (occ > 0) || byp;
    check("inst_valid", bus.inst_valid, exp_iv);
    if (exp_iv) begin
      exp_pc = (occ > 0) ? exp_q[0] : pend[0].addr;
      check("inst_pc", bus.inst_pc, exp_pc);
      check("inst_data", bus.inst_data, mem_word(exp_pc));
    end
    check("fifo_overflow", {31'b0, dut.f_push && dut.f_full}, 32'd0);
    acc = exp_rv && ready;
    if (!redir && occ > 0 && iready) void'(exp_q.pop_front());
    if (rsp) begin
      h = pend.pop_front();
      if (h.epoch == epoch && !redir && !byp) exp_q.push_back(h.addr);
    end
    if (acc) begin
      pend.push_back('{m_pc, epoch, cyc + 1});
      m_pc = m_pc + 32'd4;
    end
    if (redir) begin
      epoch++;
      exp_q.delete();
      m_pc = rpc & ~32'h3;
    end
    cyc++;
  endtask

  task automatic idle_inputs();
    bus.mem_req_ready  = 1'b0;
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.mem_rsp_valid  = 1'b0;
    bus.mem_rsp_data   = 32'h0;
  endtask

  task automatic model_reset();
    pend.delete();
    exp_q.delete();
    epoch++;
    m_pc = RST_PC;
  endtask

  int i;

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    #1;
    check("rst_req_valid", bus.mem_req_valid, 32'd0);
    check("rst_inst_valid", bus.inst_valid, 32'd0);
    check("rst_inst_pc", bus.inst_pc, 32'd0);
    check("rst_inst_data", bus.inst_data, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // 1: free-running sequential fetch
    set_knobs(100, 100, 100, 0);
    repeat (12) cycle();

    // 2: core stalls, FIFO fills to DEPTH, then drains in order
    set_knobs(100, 100, 0, 0);
    repeat (15) cycle();
    check("t2_fill", exp_q.size(), DEPTH);
    set_knobs(100, 100, 100, 0);
    repeat (12) cycle();

    // 3: redirect with two requests in flight
    set_knobs(100, 0, 100, 0);
    for (i = 0; i < 40 && pend.size() != 2; i++) cycle();
    check("t3_two_out", pend.size(), 2);
    cycle(1'b1, 32'h0000_1003);
    set_knobs(100, 100, 100, 0);
    repeat (10) cycle();

    // 4: redirect coinciding with a response
    set_knobs(100, 0, 100, 0);
    for (i = 0; i < 40 && pend.size() == 0; i++) cycle();
    check("t4_out", (pend.size() > 0), 32'd1);
    cycle(1'b1, 32'h0000_2000, 1'b1);
    set_knobs(100, 100, 100, 0);
    repeat (10) cycle();

    // 5: address wrap past 0xFFFF_FFFC
    cycle(1'b1, 32'hFFFF_FFF8);
    repeat (12) cycle();

    // 6: async reset mid-stream with 3 FIFO entries
    set_knobs(100, 100, 0, 0);
    for (i = 0; i < 40 && exp_q.size() != 3; i++) cycle();
    check("t6_three", exp_q.size(), 3);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("t6_req_valid", bus.mem_req_valid, 32'd0);
    check("t6_inst_valid", bus.inst_valid, 32'd0);
    check("t6_inst_pc", bus.inst_pc, 32'd0);
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    set_knobs(100, 100, 100, 0);
    repeat (8) cycle();

    // randomized traffic with varying knobs
    for (int k = 0; k < 20; k++) begin
      set_knobs($urandom_range(30, 100), $urandom_range(20, 100),
                $urandom_range(0, 100), $urandom_range(0, 8));
      repeat (150) cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
